// File: rtl/pwm_duty_capture_pkg.sv
// Shared definitions for the PWM duty-cycle capture block: FSM encoding and
// window-length helper.
package pwm_duty_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } cap_state_t;

  // Number of clk cycles in one measurement window (one PWM period).
  function automatic int unsigned win_len(input int unsigned cnt_w);
    return 32'd1 << cnt_w;
  endfunction

endpackage

// File: rtl/pwm_duty_capture_if.sv
// Signal bundle between a PWM source/consumer (master) and the capture block (slave).
interface pwm_duty_capture_if #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 8
);
  logic                      en;
  logic [NUM_CH-1:0]         pwm_in;
  logic [NUM_CH*CNT_W-1:0]   duty;
  logic                      duty_valid;
  logic [NUM_CH-1:0]         changed;
  logic [NUM_CH-1:0]         locked;
  logic [NUM_CH-1:0]         full_on;
  logic [NUM_CH-1:0]         full_off;

  modport master (
    output en, pwm_in,
    input  duty, duty_valid, changed, locked, full_on, full_off
  );

  modport slave (
    input  en, pwm_in,
    output duty, duty_valid, changed, locked, full_on, full_off
  );
endinterface

// File: rtl/pwm_capture_ch.sv
// One capture channel: input synchroniser, high-cycle accumulator and the
// registered per-window result with its changed/locked/full flags.
module pwm_capture_ch
  import pwm_duty_capture_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TOL         = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             active,      // window in progress this cycle
  input  logic             last,        // final cycle of the window
  input  logic             report,      // last cycle of a RUN window
  input  logic             prime_done,  // last cycle of the PRIME window
  input  logic             abort,       // enable fell: drop window, clear lock
  output logic [CNT_W-1:0] duty,
  output logic             changed,
  output logic             locked,
  output logic             full_on,
  output logic             full_off
);

  localparam logic [CNT_W:0] FULL  = (CNT_W+1)'(win_len(CNT_W));
  localparam logic [CNT_W:0] TOL_W = (CNT_W+1)'(TOL);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W:0]         acc_q;
  logic [CNT_W:0]         r;
  logic [CNT_W:0]         prev_r_q;
  logic                   prev_valid_q;
  logic                   first_q;
  logic [CNT_W:0]         diff;
  logic [CNT_W-1:0]       duty_new;

  assign s        = sync_q[SYNC_STAGES-1];
  // The final cycle's sample is folded in here so no cycle is lost at the boundary.
  assign r        = acc_q + {{CNT_W{1'b0}}, s};
  assign diff     = (r >= prev_r_q) ? (r - prev_r_q) : (prev_r_q - r);
  assign duty_new = (r >= FULL) ? '1 : r[CNT_W-1:0];

  // Synchroniser shift chain for the asynchronous pin.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values;
    // blocking here would collapse the chain into a single stage.
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

  // High-cycle accumulator, restarted at each window boundary or when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 acc_q <= '0;
    else if (!active || last) acc_q <= '0;
    else                     acc_q <= r;
  end

  // Per-window result registers and comparison history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty         <= '0;
      changed      <= 1'b0;
      locked       <= 1'b0;
      full_on      <= 1'b0;
      full_off     <= 1'b0;
      prev_r_q     <= '0;
      prev_valid_q <= 1'b0;
      first_q      <= 1'b0;
    end else if (prime_done) begin
      prev_valid_q <= 1'b0;
      first_q      <= 1'b1;
    end else if (report) begin
      duty         <= duty_new;
      full_on      <= (r == FULL);
      full_off     <= (r == '0);
      changed      <= first_q || (duty_new != duty);
      locked       <= prev_valid_q && (diff <= TOL_W);
      prev_r_q     <= r;
      prev_valid_q <= 1'b1;
      first_q      <= 1'b0;
    end else if (abort) begin
      locked       <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_duty_capture.sv
// Duty-cycle capture top: window counter, IDLE/PRIME/RUN sequencing and the
// duty_valid strobe; per-channel measurement lives in pwm_capture_ch.
module pwm_duty_capture
  import pwm_duty_capture_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TOL         = 1
) (
  input  logic              clk,
  input  logic              rst,
  pwm_duty_capture_if.slave bus
);

  cap_state_t       state_q, state_d;
  logic [CNT_W-1:0] win_q;
  logic             active, last, report, prime_done, abort;
  logic [CNT_W-1:0] duty_ch [NUM_CH];

  assign active     = (state_q != ST_IDLE) && bus.en;
  assign last       = active && (win_q == '1);
  assign report     = last && (state_q == ST_RUN);
  assign prime_done = last && (state_q == ST_PRIME);
  assign abort      = (state_q != ST_IDLE) && !bus.en;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; dropping en returns to IDLE from anywhere.
  always_comb begin
    // NOTE: default assigned first so no path through the case infers a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.en) state_d = ST_PRIME;
      ST_PRIME: if (!bus.en) state_d = ST_IDLE;
                else if (last) state_d = ST_RUN;
      ST_RUN:   if (!bus.en) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Window position counter; wraps naturally every 2^CNT_W cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          win_q <= '0;
    else if (!active) win_q <= '0;
    else              win_q <= win_q + CNT_W'(1);
  end

  // One-cycle strobe coinciding with the registered per-channel results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.duty_valid <= 1'b0;
    else     bus.duty_valid <= report;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_capture_ch #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES),
      .TOL        (TOL)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .pwm_in    (bus.pwm_in[i]),
      .active    (active),
      .last      (last),
      .report    (report),
      .prime_done(prime_done),
      .abort     (abort),
      .duty      (duty_ch[i]),
      .changed   (bus.changed[i]),
      .locked    (bus.locked[i]),
      .full_on   (bus.full_on[i]),
      .full_off  (bus.full_off[i])
    );
  end

  // Pack per-channel duty codes onto the flat bus.
  always_comb begin
    bus.duty = '0;
    for (int i = 0; i < NUM_CH; i++) bus.duty[i*CNT_W +: CNT_W] = duty_ch[i];
  end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Directed bench for pwm_duty_capture with NUM_CH=8, CNT_W=8.
module tb_pwm_duty_capture;

  localparam int NUM_CH = 8;
  localparam int CNT_W  = 8;

  logic clk;
  logic rst;

  pwm_duty_capture_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  pwm_duty_capture #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(2), .TOL(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int hc [NUM_CH];   // high cycles per 256-cycle period (256 = constant high)
  int ph [NUM_CH];   // phase offset per channel
  int pc = 0;        // free-running period position
  int n;
  int seen;
  logic [63:0] exp_duty;
  logic [7:0]  d;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One negedge: drive every PWM pin from its period position.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NUM_CH; i++)
      bus.pwm_in[i] = (((pc + ph[i]) % 256) < hc[i]);
    pc++;
  endtask

  task automatic wait_pulse(input int limit, output int cnt);
    logic found;
    found = 1'b0;
    cnt   = 0;
    while (cnt < limit && !found) begin
      tick();
      cnt++;
      if (bus.duty_valid) found = 1'b1;
    end
    check("pulse_seen", found, 1);
  endtask

  function automatic logic [63:0] model_duty();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++)
      v[i*8 +: 8] = (hc[i] > 255) ? 8'd255 : 8'(hc[i]);
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.pwm_in = '0;
    for (int i = 0; i < NUM_CH; i++) begin hc[i] = 0; ph[i] = 0; end
    repeat (3) tick();

    check("rst_duty",     bus.duty,       0);
    check("rst_valid",    bus.duty_valid, 0);
    check("rst_changed",  bus.changed,    0);
    check("rst_locked",   bus.locked,     0);
    check("rst_full_on",  bus.full_on,    0);
    check("rst_full_off", bus.full_off,   0);

    rst = 1'b0;
    repeat (4) tick();

    // ch0 at 32/256, all others low.
    hc[0] = 32;
    repeat (20) tick();
    bus.en = 1'b1;
    wait_pulse(700, n);
    check("b_latency",  (n >= 512 && n <= 515), 1);
    check("b_duty",     bus.duty,     64'h20);
    check("b_full_on",  bus.full_on,  8'h00);
    check("b_full_off", bus.full_off, 8'hFE);
    check("b_changed",  bus.changed,  8'hFF);
    check("b_locked",   bus.locked,   8'h00);
    tick();
    check("b_valid_width", bus.duty_valid, 0);
    wait_pulse(300, n);
    check("b_period",   n + 1, 256);
    check("b_duty2",    bus.duty,     64'h20);
    check("b_locked2",  bus.locked,   8'hFF);
    check("b_changed2", bus.changed,  8'h00);

    // Drop en near win=100: no report, lock cleared, results held.
    repeat (99) tick();
    bus.en = 1'b0;
    seen = 0;
    repeat (400) begin
      tick();
      if (bus.duty_valid) seen++;
    end
    check("e_no_pulse", seen,         0);
    check("e_locked",   bus.locked,   8'h00);
    check("e_duty",     bus.duty,     64'h20);
    check("e_full_off", bus.full_off, 8'hFE);

    // All channels 32..224,255 with random phases.
    for (int i = 0; i < NUM_CH; i++) begin
      hc[i] = (i == 7) ? 255 : 32 * (i + 1);
      ph[i] = int'($urandom_range(0, 255));
    end
    repeat (10) tick();
    bus.en = 1'b1;
    exp_duty = model_duty();
    wait_pulse(700, n);
    check("c_latency",  (n >= 512 && n <= 515), 1);
    check("c_duty",     bus.duty,     exp_duty);
    check("c_changed",  bus.changed,  8'hFF);
    check("c_locked",   bus.locked,   8'h00);
    check("c_full_on",  bus.full_on,  8'h00);
    check("c_full_off", bus.full_off, 8'h00);
    wait_pulse(300, n);
    check("c_period",   n, 256);
    check("c_duty2",    bus.duty,     exp_duty);
    check("c_locked2",  bus.locked,   8'hFF);
    check("c_changed2", bus.changed,  8'h00);

    // Align ch1 so its period position equals the window offset.
    ph[1] = (((1 - pc) % 256) + 256) % 256;
    wait_pulse(300, n);
    wait_pulse(300, n);
    check("d_pre_ch1", bus.duty[15:8], 8'd64);

    // Step ch1 64 -> 128 at window offset 100.
    repeat (99) tick();
    hc[1] = 128;
    wait_pulse(300, n);
    d = bus.duty[15:8];
    check("d_mid_range",   (d >= 8'd64 && d <= 8'd128), 1);
    check("d_mid_changed", bus.changed[1], 1);
    check("d_mid_locked",  bus.locked[1],  0);
    wait_pulse(300, n);
    check("d_next_duty",   bus.duty[15:8], 8'd128);
    check("d_next_locked", bus.locked[1],  0);
    wait_pulse(300, n);
    check("d_settled_locked",  bus.locked[1],  1);
    check("d_settled_changed", bus.changed[1], 0);

    // ch3 constant high, ch4 constant low.
    bus.en = 1'b0;
    repeat (2) tick();
    hc[3] = 256;
    hc[4] = 0;
    repeat (10) tick();
    bus.en = 1'b1;
    exp_duty = model_duty();
    wait_pulse(700, n);
    check("f_duty",     bus.duty,     exp_duty);
    check("f_full_on",  bus.full_on,  8'h08);
    check("f_full_off", bus.full_off, 8'h10);

    // Asynchronous reset mid-RUN.
    repeat (50) tick();
    rst = 1'b1;
    #1;
    check("g_duty",     bus.duty,       0);
    check("g_valid",    bus.duty_valid, 0);
    check("g_changed",  bus.changed,    0);
    check("g_locked",   bus.locked,     0);
    check("g_full_on",  bus.full_on,    0);
    check("g_full_off", bus.full_off,   0);
    repeat (3) tick();
    rst = 1'b0;
    wait_pulse(700, n);
    check("g_latency", (n >= 512 && n <= 515), 1);
    check("g_duty2",   bus.duty,    exp_duty);
    check("g_changed2", bus.changed, 8'hFF);
    check("g_locked2", bus.locked,  8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
